// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART blocks: serialiser state
// encodings, STATUS bit positions and register offsets.
package uart_pkg;

    // Serialiser states
    typedef logic [1:0] uart_state_t;
    localparam uart_state_t S_IDLE  = 2'd0;
    localparam uart_state_t S_START = 2'd1;
    localparam uart_state_t S_DATA  = 2'd2;
    localparam uart_state_t S_STOP  = 2'd3;

    // STATUS register bit positions
    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_BUSY      = 2;
    localparam int unsigned ST_OVF       = 3;
    localparam int unsigned ST_COUNT_LSB = 4;

    // Register word offsets from BASE_ADDR
    localparam logic [9:0] OFS_TXDATA = 10'd0;
    localparam logic [9:0] OFS_STATUS = 10'd1;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory port as seen by a memory-mapped peripheral.
interface mmio_uart_tx_if;

    logic [9:0]  ADDRESS;
    logic [31:0] DATA_IN;
    logic        WRITE_ENABLE;
    logic [31:0] DATA_OUT;

    modport master (
        output ADDRESS,
        output DATA_IN,
        output WRITE_ENABLE,
        input  DATA_OUT
    );

    modport slave (
        input  ADDRESS,
        input  DATA_IN,
        input  WRITE_ENABLE,
        output DATA_OUT
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separate occupancy count. A push while full is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // When full, the slot being written is the one being popped this edge
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store pushes a byte into a FIFO,
// STATUS read reports full/empty/busy/overflow/count.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [9:0]  BASE_ADDR    = 10'h3F0,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    mmio_uart_tx_if.slave     bus,
    output logic              TX
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    uart_state_t       state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              tx_r;
    logic              overflow;

    logic              sel_tx;
    logic              sel_st;
    logic              push;
    logic              pop;
    logic              baud_last;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       status;
    logic              unused_data_hi;

    assign sel_tx    = (bus.ADDRESS == BASE_ADDR + OFS_TXDATA);
    assign sel_st    = (bus.ADDRESS == BASE_ADDR + OFS_STATUS);
    assign push      = bus.WRITE_ENABLE && sel_tx;
    assign pop       = (state == S_IDLE) && !fifo_empty;
    assign baud_last = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign TX        = tx_r;
    assign unused_data_hi = ^bus.DATA_IN[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .din   (bus.DATA_IN[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow: set by a dropped push, cleared by any store to STATUS
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (bus.WRITE_ENABLE && sel_st) begin
            overflow <= 1'b0;
        end
    end

    // STATUS layout and read mux; zero outside STATUS so the top level can OR with RAM
    always_comb begin
        status                             = '0;
        status[ST_FULL]                    = fifo_full;
        status[ST_EMPTY]                   = fifo_empty;
        status[ST_BUSY]                    = (state != S_IDLE);
        status[ST_OVF]                     = overflow;
        status[ST_COUNT_LSB +: CNT_W]      = fifo_count;
        bus.DATA_OUT                       = sel_st ? status : '0;
    end

    // Serialiser: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT long
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_r    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift <= fifo_dout;
                        tx_r  <= 1'b0;
                        baud  <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx_r    <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_r  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_r    <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud  <= '0;
                        state <= S_IDLE;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queue-based line model compared every cycle,
// directed literal checks, then randomized bus traffic.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [9:0]  BASE  = 10'h3F0;
    localparam logic [9:0]  STAT  = 10'h3F1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus),
        .TX    (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A frame is 10*CPB line cycles indexed by k; between frames the line is high.
    byte unsigned mq[$];
    bit           m_busy = 1'b0;
    int           m_k    = 0;
    logic [7:0]   m_byte = '0;
    bit           m_ovf  = 1'b0;
    logic         m_tx   = 1'b1;

    function automatic logic frame_level(input int k, input logic [7:0] b);
        if (k < int'(CPB)) return 1'b0;
        if (k < int'(9 * CPB)) return b[(k - int'(CPB)) / int'(CPB)];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [9:0] a);
        logic [31:0] r;
        r = '0;
        if (a == STAT) begin
            r[0]   = (mq.size() == DEPTH);
            r[1]   = (mq.size() == 0);
            r[2]   = m_busy;
            r[3]   = m_ovf;
            r[8:4] = 5'(mq.size());
        end
        return r;
    endfunction

    always @(posedge clk) begin
        bit do_pop;
        int pre;
        if (rst) begin
            mq.delete();
            m_busy = 1'b0;
            m_k    = 0;
            m_ovf  = 1'b0;
        end else begin
            pre    = mq.size();
            do_pop = 1'b0;
            if (m_busy) begin
                m_k++;
                if (m_k == int'(10 * CPB)) m_busy = 1'b0;
            end else if (pre > 0) begin
                m_byte = mq.pop_front();
                m_busy = 1'b1;
                m_k    = 0;
                do_pop = 1'b1;
            end
            if (bus.WRITE_ENABLE && bus.ADDRESS == BASE) begin
                if (pre < int'(DEPTH) || do_pop) mq.push_back(bus.DATA_IN[7:0]);
                else m_ovf = 1'b1;
            end
            if (bus.WRITE_ENABLE && bus.ADDRESS == STAT) m_ovf = 1'b0;
        end
        m_tx = m_busy ? frame_level(m_k, m_byte) : 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("tx_line", 32'(tx), 32'(m_tx));
        check("data_out", bus.DATA_OUT, model_read(bus.ADDRESS));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [9:0] a, input logic [31:0] d, input logic we, input logic r);
        bus.ADDRESS      = a;
        bus.DATA_IN      = d;
        bus.WRITE_ENABLE = we;
        rst              = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(10'h000, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic peek(input string name, input logic [9:0] a, input logic [31:0] exp);
        bus.ADDRESS      = a;
        bus.WRITE_ENABLE = 1'b0;
        #1;
        check(name, bus.DATA_OUT, exp);
    endtask

    initial begin
        logic [9:0] fr;
        bit         found;
        int         r;
        logic [9:0] a;

        bus.ADDRESS      = '0;
        bus.DATA_IN      = '0;
        bus.WRITE_ENABLE = 1'b0;

        // 1. reset state
        drive(10'h000, 32'h0, 1'b0, 1'b1);
        drive(10'h000, 32'h0, 1'b0, 1'b1);
        peek("t1_status", STAT, 32'h0000_0002);
        check("t1_tx", 32'(tx), 32'h1);
        peek("t1_other", 10'h100, 32'h0);

        // 2. single byte 0x55: start, 1,0,1,0,1,0,1,0, stop
        fr = {1'b1, 8'h55, 1'b0};
        drive(BASE, 32'hDEAD_BE55, 1'b1, 1'b0);
        for (int i = 0; i < int'(10 * CPB); i++) begin
            idle(1);
            check("t2_frame", 32'(tx), 32'(fr[i / int'(CPB)]));
            if (i == 20) peek("t2_busy", STAT, 32'h0000_0006);
        end
        idle(1);
        peek("t2_done", STAT, 32'h0000_0002);

        // 3. six back-to-back stores: one popped, four buffered, sixth dropped
        for (int b = 1; b <= 6; b++) drive(BASE, 32'(b), 1'b1, 1'b0);
        peek("t3_full_ovf", STAT, 32'h0000_004D);
        idle(210);
        peek("t3_drained", STAT, 32'h0000_000A);
        drive(STAT, 32'h0, 1'b1, 1'b0);
        peek("t3_ovf_clr", STAT, 32'h0000_0002);

        // 4. push while full on the same edge the serialiser pops
        drive(10'h000, 32'h0, 1'b0, 1'b1);
        for (int b = 0; b < 5; b++) drive(BASE, 32'hA1 + 32'(b), 1'b1, 1'b0);
        peek("t4_full", STAT, 32'h0000_0045);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!m_busy && mq.size() > 0) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        check("t4_wait_pop", 32'(found), 32'h1);
        drive(BASE, 32'hB6, 1'b1, 1'b0);
        peek("t4_pop_push", STAT, 32'h0000_0045);
        drive(BASE, 32'hC7, 1'b1, 1'b0);
        peek("t4_ovf_set", STAT, 32'h0000_004D);
        drive(STAT, 32'h0, 1'b1, 1'b0);
        peek("t4_ovf_clr", STAT, 32'h0000_0045);
        idle(250);

        // 5. reset in the middle of data bit 3 (0xC3 has bit3 = 0)
        drive(10'h000, 32'h0, 1'b0, 1'b1);
        drive(BASE, 32'hC3, 1'b1, 1'b0);
        drive(BASE, 32'h11, 1'b1, 1'b0);
        drive(BASE, 32'h22, 1'b1, 1'b0);
        idle(16);
        check("t5_bit3", 32'(tx), 32'h0);
        drive(10'h000, 32'h0, 1'b0, 1'b1);
        check("t5_tx_abort", 32'(tx), 32'h1);
        peek("t5_status", STAT, 32'h0000_0002);
        for (int i = 0; i < 60; i++) begin
            idle(1);
            check("t5_quiet", 32'(tx), 32'h1);
        end

        // 6. stores to neighbouring addresses are ignored
        drive(10'h3EF, 32'h77, 1'b1, 1'b0);
        drive(10'h3F2, 32'h88, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("t6_tx", 32'(tx), 32'h1);
        end
        peek("t6_status", STAT, 32'h0000_0002);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 24) begin
                drive(BASE, $urandom, 1'b1, 1'b0);
            end else if (r < 28) begin
                drive(STAT, $urandom, 1'b1, 1'b0);
            end else if (r < 29) begin
                drive(10'h000, 32'h0, 1'b0, 1'b1);
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = BASE;
                    1:       a = STAT;
                    default: a = 10'($urandom);
                endcase
                drive(a, $urandom, (a != BASE && a != STAT) ? 1'($urandom) : 1'b0, 1'b0);
            end
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
